// File: rtl/arb_pkg.sv
// Shared types for the fetch/data memory port arbiter.
//   arb_state_e : controller state (IDLE, ISSUE, WAIT_RD)
//   arb_owner_e : which requester owns the outstanding transaction
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_RD = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } arb_owner_e;

endpackage

// File: rtl/fair_counter.sv
// Fairness counter: counts data grants made while fetch is waiting.
//   clk, rst_n : clock, synchronous active-low reset
//   inc        : count one data grant (saturates at LIMIT)
//   clr        : return to zero (takes priority over inc)
//   at_limit   : counter equals LIMIT
module fair_counter #(
  parameter int unsigned LIMIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic clr,
  output logic at_limit
);

  localparam int unsigned CW = (LIMIT < 1) ? 1 : $clog2(LIMIT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign at_limit = (cnt_q == CW'(LIMIT));

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && !at_limit) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between an instruction-fetch port and a
// data port, one transaction outstanding at a time. Data has priority
// unless fetch has been passed over FAIR_LIMIT times in a row.
//   clk, rst_n                      : clock, synchronous active-low reset
//   if_req/if_addr                  : fetch read request (held until if_gnt)
//   if_gnt/if_rvalid/if_rdata       : fetch accept pulse, read data
//   d_req/d_we/d_addr/d_wdata       : data request (held until d_gnt)
//   d_gnt/d_rvalid/d_rdata          : data accept pulse, completion, read data
//   m_req/m_we/m_addr/m_wdata       : memory request, held until m_ack
//   m_ack/m_rvalid/m_rdata          : memory accept, read data return
module mem_port_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned FAIR_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              m_req,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic              m_ack,
  input  logic              m_rvalid,
  input  logic [DATA_W-1:0] m_rdata
);

  arb_state_e        state_q, state_d;
  arb_owner_e        owner_q, owner_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              at_limit, fc_inc, fc_clr;

  fair_counter #(.LIMIT(FAIR_LIMIT)) u_fair (
    .clk      (clk),
    .rst_n    (rst_n),
    .inc      (fc_inc),
    .clr      (fc_clr),
    .at_limit (at_limit)
  );

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    if_gnt    = 1'b0;
    d_gnt     = 1'b0;
    if_rvalid = 1'b0;
    d_rvalid  = 1'b0;
    fc_inc    = 1'b0;
    fc_clr    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (if_req || d_req) begin
          if (if_req && (!d_req || at_limit)) begin
            if_gnt  = 1'b1;
            owner_d = OWN_IF;
            we_d    = 1'b0;
            addr_d  = if_addr;
            wdata_d = '0;
            fc_clr  = 1'b1;
          end else begin
            d_gnt   = 1'b1;
            owner_d = OWN_D;
            we_d    = d_we;
            addr_d  = d_addr;
            wdata_d = d_wdata;
            // Only grants that make fetch wait count towards fairness.
            fc_inc  = if_req;
            fc_clr  = !if_req;
          end
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (m_ack) begin
          if (we_q) begin
            d_rvalid = 1'b1;
            state_d  = IDLE;
          end else begin
            state_d  = WAIT_RD;
          end
        end
      end
      WAIT_RD: begin
        if (m_rvalid) begin
          if (owner_q == OWN_IF) begin
            if_rvalid = 1'b1;
          end else begin
            d_rvalid  = 1'b1;
          end
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Nothing is granted or completed while reset is asserted.
    if (!rst_n) begin
      if_gnt    = 1'b0;
      d_gnt     = 1'b0;
      if_rvalid = 1'b0;
      d_rvalid  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= OWN_IF;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign m_req    = (state_q == ISSUE);
  assign m_we     = we_q;
  assign m_addr   = addr_q;
  assign m_wdata  = wdata_q;
  assign if_rdata = m_rdata;
  assign d_rdata  = m_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  localparam int unsigned AW  = 32;
  localparam int unsigned DW  = 32;
  localparam int unsigned LIM = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          if_req, if_gnt, if_rvalid;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          d_req, d_we, d_gnt, d_rvalid;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata, d_rdata;
  logic          m_req, m_we, m_ack, m_rvalid;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_rdata;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FAIR_LIMIT(LIM)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_ack(m_ack), .m_rvalid(m_rvalid), .m_rdata(m_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change just after the rising edge; outputs are sampled on the falling edge.
  task automatic drive_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  // Transaction-level reference state for the randomized phase.
  logic [DW-1:0] mem [16];
  int            ph;        // 0 free, 1 request presented, 2 awaiting read data
  int            nph;
  int            cnt;       // data grants in a row while fetch waited
  int            rd_wait;   // cycles until the memory returns read data, -1 none
  logic [3:0]    rd_addr;
  logic          t_own_if, t_we;
  logic [AW-1:0] t_addr;
  logic [DW-1:0] t_wdata;
  logic          got_if, got_d, exp_ig, exp_dg, exp_irv, exp_drv;

  initial begin
    rst_n = 1'b0; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
    d_addr = '0; d_wdata = '0; m_ack = 1'b0; m_rvalid = 1'b0; m_rdata = '0;

    // Reset state, with requests and memory strobes active during reset.
    drive_edge();
    if_req = 1'b1; d_req = 1'b1; m_rvalid = 1'b1;
    sample();
    chk("rst_if_gnt", 64'(if_gnt), 64'd0);
    chk("rst_d_gnt", 64'(d_gnt), 64'd0);
    chk("rst_rvalid", 64'({if_rvalid, d_rvalid}), 64'd0);
    chk("rst_m_req", 64'(m_req), 64'd0);
    chk("rst_m_we", 64'(m_we), 64'd0);
    chk("rst_m_addr", 64'(m_addr), 64'd0);
    chk("rst_m_wdata", 64'(m_wdata), 64'd0);
    drive_edge();
    rst_n = 1'b1; if_req = 1'b0; d_req = 1'b0; m_rvalid = 1'b0;
    sample();
    chk("idle_gnt", 64'({if_gnt, d_gnt}), 64'd0);

    // Fetch read: grant, request with immediate ack, data one cycle later.
    drive_edge();
    if_req = 1'b1; if_addr = 32'h100;
    sample();
    chk("f_if_gnt", 64'(if_gnt), 64'd1);
    chk("f_d_gnt", 64'(d_gnt), 64'd0);
    drive_edge();
    if_req = 1'b0; m_ack = 1'b1;
    sample();
    chk("f_m_req", 64'(m_req), 64'd1);
    chk("f_m_addr", 64'(m_addr), 64'h100);
    chk("f_m_we", 64'(m_we), 64'd0);
    chk("f_no_rv_issue", 64'({if_rvalid, d_rvalid}), 64'd0);
    drive_edge();
    m_ack = 1'b0; m_rvalid = 1'b1; m_rdata = 32'hDEADBEEF;
    sample();
    chk("f_if_rvalid", 64'(if_rvalid), 64'd1);
    chk("f_d_rvalid", 64'(d_rvalid), 64'd0);
    chk("f_if_rdata", 64'(if_rdata), 64'hDEADBEEF);
    chk("f_m_req_wr", 64'(m_req), 64'd0);
    drive_edge();
    m_rvalid = 1'b0;
    sample();
    chk("f_done_rv", 64'(if_rvalid), 64'd0);

    // Data write with ack held back three cycles.
    drive_edge();
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'h12345678;
    sample();
    chk("w_d_gnt", 64'(d_gnt), 64'd1);
    chk("w_if_gnt", 64'(if_gnt), 64'd0);
    for (int i = 0; i < 3; i++) begin
      drive_edge();
      d_req = 1'b0; d_wdata = 32'hFFFF0000; d_addr = 32'h0;
      m_ack = (i == 2);
      sample();
      chk($sformatf("w_m_req_%0d", i), 64'(m_req), 64'd1);
      chk($sformatf("w_fields_%0d", i), {m_we, m_addr[30:0], m_wdata}, {1'b1, 31'h40, 32'h12345678});
      chk($sformatf("w_d_rvalid_%0d", i), 64'(d_rvalid), 64'(i == 2));
    end
    drive_edge();
    m_ack = 1'b0;
    sample();
    chk("w_after_m_req", 64'(m_req), 64'd0);
    chk("w_after_rv", 64'(d_rvalid), 64'd0);

    // Contention: both ports hold read requests continuously.
    drive_edge();
    if_req = 1'b1; if_addr = 32'h200; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h80;
    for (int i = 0; i < 10; i++) begin
      logic want_if;
      want_if = ((i % (LIM + 1)) == LIM);
      sample();
      chk($sformatf("c_gnt_%0d", i), 64'({if_gnt, d_gnt}), 64'({want_if, !want_if}));
      drive_edge();
      m_ack = 1'b1;
      sample();
      chk($sformatf("c_m_addr_%0d", i), 64'(m_addr), want_if ? 64'h200 : 64'h80);
      drive_edge();
      m_ack = 1'b0; m_rvalid = 1'b1; m_rdata = 32'hA0000000 + 32'(i);
      sample();
      chk($sformatf("c_rv_%0d", i), 64'({if_rvalid, d_rvalid}), 64'({want_if, !want_if}));
      chk($sformatf("c_rdata_%0d", i), 64'(want_if ? if_rdata : d_rdata), 64'(32'hA0000000 + 32'(i)));
      drive_edge();
      m_rvalid = 1'b0;
    end
    if_req = 1'b0; d_req = 1'b0;

    // Spurious memory strobes: rvalid while idle, ack while awaiting read data.
    m_rvalid = 1'b1; m_rdata = 32'h55;
    sample();
    chk("s_idle_rv", 64'({if_rvalid, d_rvalid}), 64'd0);
    chk("s_idle_m_req", 64'(m_req), 64'd0);
    drive_edge();
    m_rvalid = 1'b0; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h44;
    sample();
    chk("s_d_gnt", 64'(d_gnt), 64'd1);
    drive_edge();
    d_req = 1'b0; m_ack = 1'b1;
    sample();
    drive_edge();
    m_ack = 1'b1;
    sample();
    chk("s_wait_rv", 64'({if_rvalid, d_rvalid}), 64'd0);
    chk("s_wait_m_req", 64'(m_req), 64'd0);
    drive_edge();
    m_ack = 1'b0; m_rvalid = 1'b1; m_rdata = 32'hCAFE0001;
    sample();
    chk("s_d_rvalid", 64'({if_rvalid, d_rvalid}), 64'b01);
    chk("s_d_rdata", 64'(d_rdata), 64'hCAFE0001);
    drive_edge();
    m_rvalid = 1'b0;

    // Reset while awaiting read data; a late rvalid must be dropped.
    if_req = 1'b1; if_addr = 32'h300;
    sample();
    chk("r_if_gnt", 64'(if_gnt), 64'd1);
    drive_edge();
    if_req = 1'b0; m_ack = 1'b1;
    sample();
    drive_edge();
    m_ack = 1'b0; rst_n = 1'b0;
    sample();
    drive_edge();
    rst_n = 1'b1; m_rvalid = 1'b1; m_rdata = 32'hBAD0BAD0;
    sample();
    chk("r_late_rv", 64'({if_rvalid, d_rvalid}), 64'd0);
    chk("r_m_req", 64'(m_req), 64'd0);
    drive_edge();
    m_rvalid = 1'b0; if_req = 1'b1; if_addr = 32'h304;
    sample();
    chk("r_fresh_gnt", 64'(if_gnt), 64'd1);
    drive_edge();
    if_req = 1'b0; m_ack = 1'b1;
    sample();
    chk("r_fresh_addr", 64'(m_addr), 64'h304);
    drive_edge();
    m_ack = 1'b0; m_rvalid = 1'b1; m_rdata = 32'h600D600D;
    sample();
    chk("r_fresh_rv", 64'({if_rvalid, d_rvalid}), 64'b10);
    drive_edge();
    m_rvalid = 1'b0;

    // Randomized traffic against a transaction-level model.
    rst_n = 1'b0;
    for (int i = 0; i < 16; i++) mem[i] = $urandom;
    sample();
    drive_edge();
    rst_n = 1'b1;
    ph = 0; cnt = 0; rd_wait = -1; rd_addr = '0;
    t_own_if = 1'b0; t_we = 1'b0; t_addr = '0; t_wdata = '0;
    got_if = 1'b1; got_d = 1'b1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (got_if || !if_req) begin
        if_req  = ($urandom_range(0, 2) != 0);
        if_addr = 32'($urandom_range(0, 15));
      end
      if (got_d || !d_req) begin
        d_req   = ($urandom_range(0, 2) != 0);
        d_we    = $urandom_range(0, 1) == 1;
        d_addr  = 32'($urandom_range(0, 15));
        d_wdata = $urandom;
      end
      got_if = 1'b0; got_d = 1'b0;
      m_ack = $urandom_range(0, 1) == 1;
      if (rd_wait == 0) begin
        m_rvalid = 1'b1; m_rdata = mem[rd_addr]; rd_wait = -1;
      end else begin
        m_rvalid = (rd_wait < 0) && ($urandom_range(0, 5) == 0);
        m_rdata  = $urandom;
        if (rd_wait > 0) rd_wait--;
      end

      sample();
      exp_ig = 1'b0; exp_dg = 1'b0; exp_irv = 1'b0; exp_drv = 1'b0;
      if (ph == 0 && (if_req || d_req)) begin
        if (if_req && (!d_req || cnt == LIM)) exp_ig = 1'b1;
        else exp_dg = 1'b1;
      end
      chk("rnd_gnt", 64'({if_gnt, d_gnt}), 64'({exp_ig, exp_dg}));
      chk("rnd_m_req", 64'(m_req), 64'(ph == 1));
      if (ph == 1) begin
        chk("rnd_m_addr", 64'(m_addr), 64'(t_addr));
        chk("rnd_m_we", 64'(m_we), 64'(t_we));
        if (t_we) chk("rnd_m_wdata", 64'(m_wdata), 64'(t_wdata));
      end
      nph = ph;
      if (ph == 1 && m_ack) begin
        if (t_we) begin
          exp_drv = 1'b1;
          mem[t_addr[3:0]] = t_wdata;
          nph = 0;
        end else begin
          nph = 2;
          rd_wait = $urandom_range(0, 2);
          rd_addr = t_addr[3:0];
        end
      end
      if (ph == 2 && m_rvalid) begin
        if (t_own_if) exp_irv = 1'b1;
        else exp_drv = 1'b1;
        chk("rnd_rdata", 64'(t_own_if ? if_rdata : d_rdata), 64'(mem[t_addr[3:0]]));
        nph = 0;
      end
      chk("rnd_rvalid", 64'({if_rvalid, d_rvalid}), 64'({exp_irv, exp_drv}));
      if (exp_ig) begin
        nph = 1; t_own_if = 1'b1; t_we = 1'b0; t_addr = if_addr;
        cnt = 0; got_if = 1'b1;
      end
      if (exp_dg) begin
        nph = 1; t_own_if = 1'b0; t_we = d_we; t_addr = d_addr; t_wdata = d_wdata;
        cnt = if_req ? ((cnt < LIM) ? cnt + 1 : LIM) : 0;
        got_d = 1'b1;
      end
      ph = nph;
      drive_edge();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameters SHALL be:
- ADDR_W, default 32, address width.
- DATA_W, default 32, data width.
- FAIR_LIMIT, default 4, maximum consecutive data grants while fetch waits.
REQ-002 Ports SHALL be:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- if_req  in  1  fetch read request; held until if_gnt.
- if_addr  in  ADDR_W  fetch address.
- if_gnt  out  1  one-cycle pulse; fetch request accepted.
- if_rvalid  out  1  fetch read data valid.
- if_rdata  out  DATA_W  fetch read data.
- d_req  in  1  data request; held until d_gnt.
- d_we  in  1  data write (1) / read (0).
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  data write value.
- d_gnt  out  1  one-cycle pulse; data request accepted.
- d_rvalid  out  1  data transaction complete; read data valid when read.
- d_rdata  out  DATA_W  data read data.
- m_req  out  1  memory request; held until m_ack.
- m_we  out  1  memory write enable.
- m_addr  out  ADDR_W  memory address.
- m_wdata  out  DATA_W  memory write data.
- m_ack  in  1  memory accepts request this cycle.
- m_rvalid  in  1  memory read data valid.
- m_rdata  in  DATA_W  memory read data.

Function
REQ-003 The block SHALL share one single-port memory between fetch and data, with at most one transaction outstanding at a time.
REQ-004 The FSM SHALL have states IDLE, ISSUE, WAIT_RD.
REQ-005 In IDLE with any request pending, the block SHALL pick a winner, pulse its gnt, register we/addr/wdata into m_*, record the owner, and enter ISSUE next cycle.
REQ-006 Arbitration SHALL grant data over fetch, except when the fairness counter equals FAIR_LIMIT and if_req=1, in which case fetch SHALL win.
REQ-007 The fairness counter SHALL increment on each data grant made while if_req=1, saturate at FAIR_LIMIT, and clear on any fetch grant or on any data grant made with if_req=0.
REQ-008 In ISSUE, m_req SHALL be 1. On m_ack:
- write: pulse d_rvalid in that same cycle and return to IDLE.
- read: enter WAIT_RD.
REQ-009 In WAIT_RD, on m_rvalid the block SHALL assert the owner's rvalid combinationally with rdata=m_rdata, then return to IDLE next cycle.
REQ-010 Minimum read latency SHALL be 2 cycles: gnt at N, m_req/m_ack at N+1, rvalid at N+2 if m_rvalid arrives at N+2; back-to-back grants are possible at N+3.
REQ-011 m_ack outside ISSUE and m_rvalid outside WAIT_RD SHALL be ignored and not forwarded.
REQ-012 if_rdata and d_rdata SHALL carry m_rdata unconditionally; only the owner's rvalid qualifies it.
REQ-013 Simultaneous if_req and d_req in IDLE SHALL grant exactly one; the loser keeps its req asserted and is granted in a later IDLE cycle.
REQ-014 m_we, m_addr and m_wdata SHALL stay stable from entry into ISSUE until m_ack.

Reset
REQ-015 When rst_n=0 at a clock edge:
- state SHALL go to IDLE and the fairness counter to 0.
- m_req, m_we, if_gnt, d_gnt, if_rvalid and d_rvalid SHALL be 0; m_addr and m_wdata SHALL be 0.
REQ-016 Reset mid-transaction SHALL abandon the transaction; a late m_rvalid SHALL NOT produce if_rvalid or d_rvalid.

Structure
REQ-017 The state enum (IDLE/ISSUE/WAIT_RD) and owner enum (OWN_IF/OWN_D) SHALL be defined in shared package arb_pkg.
REQ-018 The fairness counter SHALL be sub-module fair_counter (parameter LIMIT; inputs inc, clr; output at_limit).

Verification
REQ-019 Fetch read: if_req=1, addr 0x100; memory acks at once and returns 0xDEADBEEF one cycle later -> if_gnt at cycle 1, m_req at 2, if_rvalid with 0xDEADBEEF at 3.
REQ-020 Data write: d_we=1, addr 0x40, wdata 0x12345678, m_ack delayed 3 cycles -> m_req held 3 cycles with stable fields; d_rvalid pulses in the m_ack cycle.
REQ-021 Contention: if_req and d_req held continuously with reads, FAIR_LIMIT=4 -> grant order D,D,D,D,IF,D,D,D,D,IF.
REQ-022 Spurious inputs: m_rvalid pulsed in IDLE and m_ack pulsed in WAIT_RD -> no rvalid, no state change.
REQ-023 Reset in WAIT_RD, then m_rvalid the next cycle -> no rvalid; state IDLE; a fresh if_req is granted normally.
